// File: rtl/fft_4_ctrl.sv
// Frame sequencer for the fft_4 core: gathers 4 serial samples, runs the core for FFT_LAT clocks,
// then replays the 4 bins serially with valid/ready and a frame-end marker.
module fft_4_ctrl #(
    parameter int IN_W    = 8,
    parameter int OUT_W   = 10,
    parameter int FFT_LAT = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [IN_W-1:0]  s_re,
    input  logic signed [IN_W-1:0]  s_im,
    output logic                    fft_en,
    output logic signed [IN_W-1:0]  fft_reA,
    output logic signed [IN_W-1:0]  fft_reB,
    output logic signed [IN_W-1:0]  fft_reC,
    output logic signed [IN_W-1:0]  fft_reD,
    output logic signed [IN_W-1:0]  fft_imA,
    output logic signed [IN_W-1:0]  fft_imB,
    output logic signed [IN_W-1:0]  fft_imC,
    output logic signed [IN_W-1:0]  fft_imD,
    input  logic signed [OUT_W-1:0] fft_re0,
    input  logic signed [OUT_W-1:0] fft_re1,
    input  logic signed [OUT_W-1:0] fft_re2,
    input  logic signed [OUT_W-1:0] fft_re3,
    input  logic signed [OUT_W-1:0] fft_im0,
    input  logic signed [OUT_W-1:0] fft_im1,
    input  logic signed [OUT_W-1:0] fft_im2,
    input  logic signed [OUT_W-1:0] fft_im3,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic signed [OUT_W-1:0] m_re,
    output logic signed [OUT_W-1:0] m_im,
    output logic                    m_last,
    output logic                    busy
);

    localparam int LAT_W = (FFT_LAT > 1) ? $clog2(FFT_LAT) : 1;

    typedef enum logic [1:0] {FILL, RUN, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              cnt_q, cnt_d;
    logic [LAT_W-1:0]        lat_q, lat_d;
    logic [1:0]              idx_q, idx_d;
    logic signed [IN_W-1:0]  smp_re_q [4];
    logic signed [IN_W-1:0]  smp_re_d [4];
    logic signed [IN_W-1:0]  smp_im_q [4];
    logic signed [IN_W-1:0]  smp_im_d [4];
    logic signed [OUT_W-1:0] bin_re_q [4];
    logic signed [OUT_W-1:0] bin_re_d [4];
    logic signed [OUT_W-1:0] bin_im_q [4];
    logic signed [OUT_W-1:0] bin_im_d [4];
    logic                    s_xfer;
    logic                    m_xfer;

    // Handshake outputs are gated by rst so nothing is offered during a reset cycle.
    assign s_ready = rst && (state_q == FILL);
    assign m_valid = rst && (state_q == DRAIN);
    assign fft_en  = rst && (state_q == RUN);
    assign busy    = rst && ((state_q != FILL) || (cnt_q != 2'd0));
    assign m_last  = m_valid && (idx_q == 2'd3);
    assign m_re    = m_valid ? bin_re_q[idx_q] : '0;
    assign m_im    = m_valid ? bin_im_q[idx_q] : '0;
    assign s_xfer  = s_valid && s_ready;
    assign m_xfer  = m_valid && m_ready;

    assign fft_reA = smp_re_q[0];
    assign fft_reB = smp_re_q[1];
    assign fft_reC = smp_re_q[2];
    assign fft_reD = smp_re_q[3];
    assign fft_imA = smp_im_q[0];
    assign fft_imB = smp_im_q[1];
    assign fft_imC = smp_im_q[2];
    assign fft_imD = smp_im_q[3];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lat_d    = lat_q;
        idx_d    = idx_q;
        smp_re_d = smp_re_q;
        smp_im_d = smp_im_q;
        bin_re_d = bin_re_q;
        bin_im_d = bin_im_q;
        case (state_q)
            FILL: begin
                if (s_xfer) begin
                    smp_re_d[cnt_q] = s_re;
                    smp_im_d[cnt_q] = s_im;
                    cnt_d           = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = RUN;
                        lat_d   = '0;
                    end
                end
            end
            RUN: begin
                // The core output is sampled on the final enabled cycle.
                if (lat_q == LAT_W'(FFT_LAT - 1)) begin
                    bin_re_d = '{fft_re0, fft_re1, fft_re2, fft_re3};
                    bin_im_d = '{fft_im0, fft_im1, fft_im2, fft_im3};
                    idx_d    = 2'd0;
                    state_d  = DRAIN;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            DRAIN: begin
                if (m_xfer) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = FILL;
                        cnt_d   = 2'd0;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= FILL;
            cnt_q   <= 2'd0;
            lat_q   <= '0;
            idx_q   <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                smp_re_q[i] <= '0;
                smp_im_q[i] <= '0;
                bin_re_q[i] <= '0;
                bin_im_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lat_q    <= lat_d;
            idx_q    <= idx_d;
            smp_re_q <= smp_re_d;
            smp_im_q <= smp_im_d;
            bin_re_q <= bin_re_d;
            bin_im_q <= bin_im_d;
        end
    end

endmodule

// File: tb/tb_fft_4_ctrl.sv
// Bench for fft_4_ctrl: behavioural fft_4 stand-in, table of frames with constant expected bins,
// scoreboard queue checked on every output handshake, plus stall / gap / reset sequences.
module tb_fft_4_ctrl;

    localparam int FFT_LAT = 2;
    localparam int NV      = 3;

    typedef struct packed {
        logic [3:0][7:0] re;
        logic [3:0][7:0] im;
        logic [3:0][9:0] bre;
        logic [3:0][9:0] bim;
    } vec_t;

    typedef struct packed {
        logic [9:0] re;
        logic [9:0] im;
        logic       last;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_valid, s_ready;
    logic signed [7:0] s_re, s_im;
    logic              fft_en;
    logic signed [7:0] fft_reA, fft_reB, fft_reC, fft_reD;
    logic signed [7:0] fft_imA, fft_imB, fft_imC, fft_imD;
    logic signed [9:0] f_re0, f_re1, f_re2, f_re3;
    logic signed [9:0] f_im0, f_im1, f_im2, f_im3;
    logic              m_valid, m_ready, m_last, busy;
    logic signed [9:0] m_re, m_im;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    vec_t tbl[NV];

    always #5 clk = ~clk;

    fft_4_ctrl #(.IN_W(8), .OUT_W(10), .FFT_LAT(FFT_LAT)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im),
        .fft_en(fft_en),
        .fft_reA(fft_reA), .fft_reB(fft_reB), .fft_reC(fft_reC), .fft_reD(fft_reD),
        .fft_imA(fft_imA), .fft_imB(fft_imB), .fft_imC(fft_imC), .fft_imD(fft_imD),
        .fft_re0(f_re0), .fft_re1(f_re1), .fft_re2(f_re2), .fft_re3(f_re3),
        .fft_im0(f_im0), .fft_im1(f_im1), .fft_im2(f_im2), .fft_im3(f_im3),
        .m_valid(m_valid), .m_ready(m_ready), .m_re(m_re), .m_im(m_im),
        .m_last(m_last), .busy(busy)
    );

    // Stand-in fft_4 with FFT_LAT=2: one enabled register stage, result valid on the last en cycle.
    logic signed [9:0] ar, ai, br, bi, cr, ci, dr, di;
    assign ar = fft_reA;
    assign ai = fft_imA;
    assign br = fft_reB;
    assign bi = fft_imB;
    assign cr = fft_reC;
    assign ci = fft_imC;
    assign dr = fft_reD;
    assign di = fft_imD;

    always @(posedge clk) begin
        if (fft_en) begin
            f_re0 <= ar + br + cr + dr;
            f_im0 <= ai + bi + ci + di;
            f_re1 <= (ar - cr) + (bi - di);
            f_im1 <= (ai - ci) - (br - dr);
            f_re2 <= ar - br + cr - dr;
            f_im2 <= ai - bi + ci - di;
            f_re3 <= (ar - cr) - (bi - di);
            f_im3 <= (ai - ci) + (br - dr);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0][7:0] pk8(input int a, input int b, input int c, input int d);
        logic [3:0][7:0] r;
        r[0] = a[7:0];
        r[1] = b[7:0];
        r[2] = c[7:0];
        r[3] = d[7:0];
        return r;
    endfunction

    function automatic logic [3:0][9:0] pk10(input int a, input int b, input int c, input int d);
        logic [3:0][9:0] r;
        r[0] = a[9:0];
        r[1] = b[9:0];
        r[2] = c[9:0];
        r[3] = d[9:0];
        return r;
    endfunction

    task automatic push_exp(input logic [3:0][9:0] bre, input logic [3:0][9:0] bim);
        for (int i = 0; i < 4; i++) exp_q.push_back('{re: bre[i], im: bim[i], last: (i == 3)});
    endtask

    // Entered and left at posedge+1.
    task automatic push_sample(input logic signed [7:0] re, input logic signed [7:0] im);
        int n = 0;
        s_valid = 1'b1;
        s_re    = re;
        s_im    = im;
        do begin
            @(negedge clk);
            n++;
        end while (!s_ready && n < 100);
        if (n >= 100) chk("accept_timeout", n, 0);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [3:0][7:0] re, input logic [3:0][7:0] im);
        for (int i = 0; i < 4; i++) push_sample($signed(re[i]), $signed(im[i]));
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("s_ready_after_last", s_ready, 1);
        chk("m_valid_after_last", m_valid, 0);
        chk("busy_idle", busy, 0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every output handshake pops and compares one expected bin.
    always @(negedge clk) begin
        if (rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_bin", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("m_re", m_re, $signed(e.re));
                chk("m_im", m_im, $signed(e.im));
                chk("m_last", m_last, e.last);
                chk("s_ready_in_drain", s_ready, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int en;
        int nsmp;
        int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
        logic [3:0][7:0] gre, gim;

        tbl[0] = '{re: pk8(3, 2, 1, 3), im: pk8(0, 0, 0, 0),
                   bre: pk10(9, 2, -1, 2), bim: pk10(0, 1, 0, -1)};
        tbl[1] = '{re: pk8(1, 1, 1, 1), im: pk8(0, 0, 0, 0),
                   bre: pk10(4, 0, 0, 0), bim: pk10(0, 0, 0, 0)};
        tbl[2] = '{re: pk8(-128, 127, -1, 0), im: pk8(5, -3, 0, 7),
                   bre: pk10(-2, -137, -256, -117), bim: pk10(9, -122, 1, 132)};

        rst     = 1'b0;
        s_valid = 1'b1;
        s_re    = 8'sd5;
        s_im    = -8'sd5;
        m_ready = 1'b1;

        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst_s_ready", s_ready, 0);
            chk("rst_m_valid", m_valid, 0);
            chk("rst_fft_en", fft_en, 0);
            chk("rst_busy", busy, 0);
            chk("rst_m_last", m_last, 0);
            chk("rst_m_re", m_re, 0);
            chk("rst_m_im", m_im, 0);
            chk("rst_fft_reA", fft_reA, 0);
            chk("rst_fft_imD", fft_imD, 0);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        chk("post_rst_s_ready", s_ready, 1);
        chk("post_rst_busy", busy, 0);
        @(posedge clk);
        #1;

        // Table frames; 0 then 1 run back to back.
        for (int v = 0; v < NV; v++) begin
            push_exp(tbl[v].bre, tbl[v].bim);
            send_frame(tbl[v].re, tbl[v].im);
            k  = 0;
            en = 0;
            while (!m_valid && k < 50) begin
                @(negedge clk);
                k++;
                if (fft_en) en++;
            end
            chk("latency", k, FFT_LAT + 1);
            chk("fft_en_cycles", en, FFT_LAT);
            wait_drain();
        end

        // Backpressure at bin 1.
        push_exp(tbl[0].bre, tbl[0].bim);
        send_frame(tbl[0].re, tbl[0].im);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!m_valid && k < 50);
        chk("bp_reach_drain", m_valid, 1);
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_m_valid", m_valid, 1);
            chk("bp_m_re", m_re, 2);
            chk("bp_m_im", m_im, 1);
            chk("bp_s_ready", s_ready, 0);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        wait_drain();

        // Gapped input: samples land only on the valid cycles.
        gre = pk8(5, -2, 7, -1);
        gim = pk8(0, 1, -1, 2);
        push_exp(pk10(9, -3, 15, -1), pk10(2, 2, -4, 0));
        nsmp = 0;
        for (int i = 0; i < 7; i++) begin
            s_valid = pat[i][0];
            if (pat[i] != 0) begin
                s_re = $signed(gre[nsmp]);
                s_im = $signed(gim[nsmp]);
                nsmp++;
            end
            @(negedge clk);
            chk("gap_no_run", fft_en, 0);
            chk("gap_s_ready", s_ready, 1);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        @(negedge clk);
        chk("gap_run_entered", fft_en, 1);
        @(posedge clk);
        #1;
        wait_drain();

        // Reset in the middle of DRAIN, right after bin 1 is taken.
        push_exp(tbl[0].bre, tbl[0].bim);
        send_frame(tbl[0].re, tbl[0].im);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!m_valid && k < 50);
        chk("mid_reach_drain", m_valid, 1);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("mid_rst_m_valid", m_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("after_rst_m_valid", m_valid, 0);
            chk("after_rst_busy", busy, 0);
        end
        @(posedge clk);
        #1;
        push_exp(pk10(1, 1, 1, 1), pk10(0, 0, 0, 0));
        send_frame(pk8(1, 0, 0, 0), pk8(0, 0, 0, 0));
        wait_drain();

        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
